// File: rtl/lamp_mode_scheduler.sv
// Turn/hazard lamp sequencer: synchronized switch inputs select a mode, and a
// prescaler steps a 4-phase lamp pattern. Mode changes land on sequence boundaries.
module lamp_mode_scheduler #(
  parameter int TICK_DIV = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       emergency,
  output logic [1:0] mode,
  output logic [1:0] phase,
  output logic       step,
  output logic       busy
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } state_t;

  // bit order: {emergency, right, left}
  logic [2:0]    sync1, sync2;
  state_t        req;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    phase_q, phase_nxt;
  logic          step_q, step_nxt;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {emergency, turn_right, turn_left};
      sync2 <= sync1;
    end
  end

  always_comb begin
    req = IDLE;
    if (sync2[2])                    req = HAZARD;
    else if (sync2[0] && !sync2[1])  req = LEFT;
    else if (sync2[1] && !sync2[0])  req = RIGHT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      phase_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      phase_q <= phase_nxt;
      step_q  <= step_nxt;
    end
  end

  assign tick = (state != IDLE) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    phase_nxt = phase_q;
    if (state == IDLE) begin
      state_nxt = req;
      phase_nxt = '0;
    end else if (req == HAZARD && state != HAZARD) begin
      state_nxt = HAZARD;
      phase_nxt = '0;
    end else if (tick) begin
      phase_nxt = phase_q + 2'd1;
      if (phase_q == 2'd3) state_nxt = req;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
    // step is registered, so it is raised one edge early to line up with cnt==LAST
    step_nxt = (state_nxt != IDLE) && (cnt_nxt == LAST);
  end

  always_comb begin
    mode  = state;
    phase = phase_q;
    step  = step_q;
    busy  = (state != IDLE);
  end

endmodule

// File: doc/lamp_mode_scheduler.md
LAMP_MODE_SCHEDULER -- requirements
Module: lamp_mode_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, clock cycles per lamp step; legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port turn_left  input  1  raw left-turn switch level, asynchronous to clk.
REQ-005 SHALL have port turn_right  input  1  raw right-turn switch level, asynchronous to clk.
REQ-006 SHALL have port emergency  input  1  raw hazard switch level, asynchronous to clk.
REQ-007 SHALL have port mode  output  2  current lamp mode: 00 idle, 01 left, 10 right, 11 hazard.
REQ-008 SHALL have port phase  output  2  step index within the 4-step lamp sequence, 0..3.
REQ-009 SHALL have port step  output  1  one-cycle pulse marking each lamp step advance.
REQ-010 SHALL have port busy  output  1  high whenever mode != 00.

Function
REQ-011 SHALL pass each raw input through a 2-flop synchronizer; only synchronized values feed the logic.
REQ-012 SHALL derive the request from the synchronized inputs as follows: emergency high -> HAZARD; else left only -> LEFT; right only -> RIGHT; both or none -> IDLE.
REQ-013 SHALL implement states IDLE, LEFT, RIGHT, HAZARD, encoded directly on mode (00/01/10/11).
REQ-014 SHALL, in IDLE, hold the prescaler at 0, phase at 0 and step at 0.
REQ-015 SHALL, in IDLE with a non-IDLE request, enter the requested state on the next edge with phase 0 and prescaler 0.
REQ-016 SHALL, in any non-IDLE state, increment the prescaler every cycle; on the cycle its value is TICK_DIV-1, it SHALL return to 0, step SHALL be 1 for that cycle, and phase SHALL advance by 1 mod 4 on the same edge.
REQ-017 SHALL treat a step with phase 3 as a sequence boundary; at a boundary the state SHALL be loaded from the current request (IDLE, LEFT, RIGHT or HAZARD), and phase SHALL become 0.
REQ-018 SHALL, outside a boundary, keep the state unchanged, except as given in REQ-019; a released or changed turn request SHALL take effect only at the next boundary.
REQ-019 SHALL, when the request is HAZARD and the state is LEFT or RIGHT, switch to HAZARD on the next edge regardless of phase, with phase 0 and prescaler 0 (preemption).
REQ-020 SHALL exit HAZARD only at a boundary.
REQ-021 SHALL register step, mode and phase, with no combinational path from inputs to outputs.
REQ-022 SHALL size the prescaler as $clog2(TICK_DIV) bits; the prescaler SHALL never exceed TICK_DIV-1.
REQ-023 SHALL produce step only in non-IDLE states; step high implies busy high in the same cycle.

Reset
REQ-024 SHALL, while rst is high, clear the synchronizer flops, state (IDLE), prescaler, phase and step to 0 immediately without waiting for clk, so that mode=00, phase=0, step=0 and busy=0.
REQ-025 SHALL, after rst falls mid-sequence, restart from IDLE and require a fresh synchronized request to start a new sequence.

Verification (TICK_DIV=4)
REQ-026 SHALL cover: from IDLE, turn_left held high -> mode=01 on the 3rd edge after assertion; step pulses every 4 cycles; phase 0,1,2,3,0 repeats.
REQ-027 SHALL cover: turn_left released at phase 1 -> mode stays 01 through phase 3, and becomes 00 on the step that wraps phase 3->0.
REQ-028 SHALL cover: emergency asserted while mode=01 at phase 2 -> mode=11 with phase=0 within 3 edges; after emergency is released with no turn request, mode returns to 00 only at the next boundary.
REQ-029 SHALL cover: turn_left and turn_right both high from IDLE -> mode stays 00, busy=0, no step pulses for at least 16 cycles.
REQ-030 SHALL cover: turn_left switched to turn_right at phase 1 -> mode=01 until the boundary, then mode=10 with phase 0.
REQ-031 SHALL cover: rst pulsed mid-cycle while mode=10 at phase 2 -> mode=00, phase=0, step=0 before the next clk edge.
